// File: rtl/video_regs.sv
// video_regs: bus-mapped CTRL/BG_COLOR registers; define VIDEO_REGS_SHADOW_EN to hold active values until frame_start_i
module video_regs #(
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bus_valid_i,
  output logic              bus_ready_o,
  input  logic              bus_we_i,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic [31:0]       bus_wdata_i,
  input  logic [3:0]        bus_wstrb_i,
  output logic [31:0]       bus_rdata_o,
  input  logic              frame_start_i,
  output logic              fb_en_o,
  output logic [23:0]       bg_color_o,
  output logic              update_pending_o
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t            r_state, w_state_nxt;
  logic              r_we;
  logic [ADDR_W-3:0] r_word;
  logic [23:0]       r_wdata;
  logic [2:0]        r_wstrb;
  logic              r_fb;
  logic [23:0]       r_bg;
  logic              w_resp, w_is_ctrl, w_is_bg, w_wr_bg, w_fb_nxt;
  logic [23:0]       w_bg_mask, w_bg_nxt;
  logic              w_unused;
  assign w_unused = ^{bus_addr_i[1:0], bus_wdata_i[31:24], bus_wstrb_i[3], frame_start_i};
  // handshake state register; reset abandons any access in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end
  // RESP always lasts one cycle; requests are only taken in IDLE
  always_comb begin
    w_state_nxt = IDLE;
    w_state_nxt = (r_state == RESP) ? IDLE : (bus_valid_i ? RESP : IDLE);
  end
  // capture request fields on acceptance; only bits that can reach storage are kept
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (r_state == IDLE && bus_valid_i) begin
      r_we    <= bus_we_i;
      r_word  <= bus_addr_i[ADDR_W-1:2];
      r_wdata <= bus_wdata_i[23:0];
      r_wstrb <= bus_wstrb_i[2:0];
    end
  end
  assign w_resp    = (r_state == RESP);
  assign w_is_ctrl = (r_word == '0);
  assign w_is_bg   = (r_word == (ADDR_W-2)'(1));
  assign w_wr_bg   = w_resp & r_we & w_is_bg;
  assign w_bg_mask = {{8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}} & {24{w_wr_bg}};
  assign w_fb_nxt  = (w_resp & r_we & w_is_ctrl & r_wstrb[0]) ? r_wdata[0] : r_fb;
  assign w_bg_nxt  = (r_bg & ~w_bg_mask) | (r_wdata & w_bg_mask);
  // pending registers take byte-lane writes at the end of RESP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fb <= 1'b0;
      r_bg <= '0;
    end else begin
      r_fb <= w_fb_nxt;
      r_bg <= w_bg_nxt;
    end
  end
  assign bus_ready_o = w_resp;
  assign bus_rdata_o = (w_resp & ~r_we) ? (w_is_ctrl ? {31'b0, r_fb} : w_is_bg ? {8'b0, r_bg} : 32'b0) : 32'b0;
`ifdef VIDEO_REGS_SHADOW_EN
  logic        r_afb, r_upd, w_afb_nxt;
  logic [23:0] r_abg, w_abg_nxt;
  assign w_afb_nxt = frame_start_i ? r_fb : r_afb;
  assign w_abg_nxt = frame_start_i ? r_bg : r_abg;
  // active copy loads the pre-write pending value on frame start; flag tracks the next-cycle difference
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_afb <= 1'b0;
      r_abg <= '0;
      r_upd <= 1'b0;
    end else begin
      r_afb <= w_afb_nxt;
      r_abg <= w_abg_nxt;
      r_upd <= (w_fb_nxt != w_afb_nxt) || (w_bg_nxt != w_abg_nxt);
    end
  end
  assign fb_en_o          = r_afb;
  assign bg_color_o       = r_abg;
  assign update_pending_o = r_upd;
`else
  assign fb_en_o          = r_fb;
  assign bg_color_o       = r_bg;
  assign update_pending_o = 1'b0;
`endif
endmodule

// File: tb/tb_video_regs.sv
// tb_video_regs: directed plus randomized bus/frame traffic checked against a register-image model
module tb_video_regs;
  logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, we = 1'b0, fs = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        ready, fb_en, upd;
  logic [31:0] rdata, last_rd;
  logic [23:0] bg;
  int          cmp = 0, bad = 0;
`ifdef VIDEO_REGS_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif
  logic [31:0] m_ctrl = '0, m_bg = '0, a_ctrl = '0, a_bg = '0;

  always #5 clk = ~clk;

  video_regs #(.ADDR_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .bus_valid_i(valid), .bus_ready_o(ready), .bus_we_i(we),
    .bus_addr_i(addr), .bus_wdata_i(wdata), .bus_wstrb_i(wstrb), .bus_rdata_o(rdata),
    .frame_start_i(fs), .fb_en_o(fb_en), .bg_color_o(bg), .update_pending_o(upd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    return ((a & 3'b100) == 3'b100) ? m_bg : m_ctrl;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, "_fb"}, {31'b0, fb_en}, a_ctrl);
    chk({tag, "_bg"}, 32'(bg), a_bg);
    chk({tag, "_upd"}, {31'b0, upd}, {31'b0, SHADOW && ((m_ctrl != a_ctrl) || (m_bg != a_bg))});
  endtask

  task automatic access(input bit w, input logic [2:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit f, input string tag);
    logic [31:0] mask;
    valid = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
    chk({tag, "_idle_rdy"}, {31'b0, ready}, 32'd0);
    @(negedge clk);
    chk({tag, "_rdy"}, {31'b0, ready}, 32'd1);
    last_rd = rdata;
    if (!w) chk({tag, "_rdata"}, rdata, m_read(a));
    valid = 1'b0; fs = f;
    @(negedge clk);
    fs = 1'b0;
    if (SHADOW && f) begin a_ctrl = m_ctrl; a_bg = m_bg; end
    if (w) begin
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      if (a[2]) m_bg   = ((m_bg & ~mask) | (d & mask)) & 32'h00FF_FFFF;
      else      m_ctrl = ((m_ctrl & ~mask) | (d & mask)) & 32'h1;
    end
    if (!SHADOW) begin a_ctrl = m_ctrl; a_bg = m_bg; end
    check_outs(tag);
    chk({tag, "_rdy_drop"}, {31'b0, ready}, 32'd0);
  endtask

  task automatic pulse(input string tag);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    if (SHADOW) begin a_ctrl = m_ctrl; a_bg = m_bg; end
    check_outs(tag);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_rdy", {31'b0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    check_outs("rst");
    rst = 1'b0;
    @(negedge clk);
    access(1'b1, 3'h4, 32'h0012_3456, 4'hF, 1'b0, "w_bg");
    access(1'b0, 3'h4, 32'h0, 4'h0, 1'b0, "r_bg");
    chk("r_bg_const", last_rd, 32'h0012_3456);
    pulse("frame1");
    chk("frame1_bg_const", 32'(bg), 32'h0012_3456);
    access(1'b1, 3'h4, 32'hFFAA_BBCC, 4'h2, 1'b0, "w_lane1");
    access(1'b0, 3'h4, 32'h0, 4'h0, 1'b0, "r_lane1");
    chk("r_lane1_const", last_rd, 32'h0012_BB56);
    access(1'b1, 3'h4, 32'hFFFF_FFFF, 4'h0, 1'b0, "w_nostrb");
    access(1'b1, 3'h0, 32'h1, 4'h1, 1'b1, "w_ctrl_fs");
    pulse("frame2");
    chk("frame2_fb_const", {31'b0, fb_en}, 32'd1);
    access(1'b0, 3'h6, 32'h0, 4'h0, 1'b0, "r_06");
    access(1'b1, 3'(4'h8), 32'hFFFF_FFFE, 4'hF, 1'b0, "w_08");
    access(1'b1, 3'h5, 32'hFFFF_FFFF, 4'hF, 1'b0, "w_05");
    access(1'b0, 3'h5, 32'h0, 4'h0, 1'b0, "r_05");
    chk("r_05_const", last_rd, 32'h00FF_FFFF);
    access(1'b0, 3'h1, 32'h0, 4'h0, 1'b0, "r_01");
    pulse("frame3");
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) pulse("rnd_frame");
      else access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                  4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), "rnd");
    end
    valid = 1'b1; we = 1'b1; addr = 3'h4; wdata = 32'h00AB_CDEF; wstrb = 4'hF;
    @(negedge clk);
    chk("mid_rdy", {31'b0, ready}, 32'd1);
    rst = 1'b1;
    #1;
    valid = 1'b0;
    chk("mid_rst_rdy", {31'b0, ready}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    m_ctrl = '0; m_bg = '0; a_ctrl = '0; a_bg = '0;
    check_outs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outs("post_rst");
    access(1'b0, 3'h0, 32'h0, 4'h0, 1'b0, "post_rst_r0");
    chk("post_rst_r0_const", last_rd, 32'd0);
    access(1'b1, 3'h4, 32'h00AB_CDEF, 4'hF, 1'b0, "w_abcdef");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
